// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the data-memory access unit: size codes,
// FSM states, the latched request record and alignment/error checks.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    typedef struct packed {
        logic        load;
        size_e       size;
        logic        is_unsigned;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // No-op requests never fault; only real accesses are checked for size/alignment.
    function automatic logic access_error(input logic load, input logic store,
                                          input logic [1:0] size, input logic [1:0] addr_lo);
        if (load && store)
            return 1'b1;
        if (!load && !store)
            return 1'b0;
        return (size == SZ_ILLEGAL) || is_misaligned(size, addr_lo);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory bus of the access unit.
// slave = the access unit itself, master = pipeline plus memory around it.
interface mem_access_unit_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_load_i;
    logic        req_store_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        stall_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_wr_o;
    logic        mem_rd_o;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  req_valid_i, req_load_i, req_store_i, req_size_i, req_unsigned_i,
               req_addr_i, req_wdata_i, mem_rdata_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, stall_o,
               mem_addr_o, mem_wdata_o, mem_wr_o, mem_rd_o
    );

    modport master (
        output req_valid_i, req_load_i, req_store_i, req_size_i, req_unsigned_i,
               req_addr_i, req_wdata_i, mem_rdata_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, stall_o,
               mem_addr_o, mem_wdata_o, mem_wr_o, mem_rd_o
    );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: merges store data into a read word and
// extracts/extends load data from it. Purely combinational.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  size_e       size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    output logic [31:0] merged_word,
    output logic [31:0] load_data
);
    logic [31:0] store_rep;
    logic [15:0] shifted;
    logic [3:0]  lane_hit;

    // Replicate the right-aligned store data so every lane sees its own copy.
    always_comb begin
        store_rep = wdata;
        case (size)
            SZ_BYTE: store_rep = {4{wdata[7:0]}};
            SZ_HALF: store_rep = {2{wdata[15:0]}};
            default: store_rep = wdata;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_hit[gi] = (size == SZ_WORD)
                               || (size == SZ_HALF && lane[1] == LANE[1])
                               || (size == SZ_BYTE && lane == LANE);
            assign merged_word[8*gi +: 8] = lane_hit[gi] ? store_rep[8*gi +: 8]
                                                         : old_word[8*gi +: 8];
        end
    endgenerate

    assign shifted = 16'(old_word >> {lane, 3'b000});

    always_comb begin
        load_data = old_word;
        case (size)
            SZ_BYTE: load_data = {{24{~is_unsigned & shifted[7]}},  shifted[7:0]};
            SZ_HALF: load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            default: load_data = old_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory initiator: word/half/byte loads and stores, sub-word stores as
// read-modify-write, pipeline stall while an access is in flight.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int RD_LATENCY = 1
)
(
    input logic              clk_i,
    input logic              rst_i,
    mem_access_unit_if.slave bus
);
    localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

    state_e            state_reg;
    req_t              req_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              ready_reg;
    logic              mem_rd_reg;
    logic              mem_wr_reg;
    logic [31:0]       mem_addr_reg;
    logic [31:0]       mem_wdata_reg;
    logic              resp_valid_reg;
    logic              resp_err_reg;
    logic [31:0]       resp_rdata_reg;

    logic              req_err;
    logic              req_noop;
    logic [31:0]       merged_word;
    logic [31:0]       load_data;

    assign req_err  = access_error(bus.req_load_i, bus.req_store_i, bus.req_size_i, bus.req_addr_i[1:0]);
    assign req_noop = ~bus.req_load_i & ~bus.req_store_i;

    // Operates on the live memory read data; results are captured on the last RD cycle.
    mem_lane_align u_lane_align (
        .old_word    (bus.mem_rdata_i),
        .wdata       (req_reg.wdata),
        .size        (req_reg.size),
        .lane        (req_reg.addr[1:0]),
        .is_unsigned (req_reg.is_unsigned),
        .merged_word (merged_word),
        .load_data   (load_data)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= ST_IDLE;
            req_reg        <= '0;
            cnt_reg        <= '0;
            ready_reg      <= 1'b1;
            mem_rd_reg     <= 1'b0;
            mem_wr_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.req_valid_i) begin
                        ready_reg <= 1'b0;
                        req_reg   <= '{load:        bus.req_load_i,
                                       size:        size_e'(bus.req_size_i),
                                       is_unsigned: bus.req_unsigned_i,
                                       addr:        bus.req_addr_i,
                                       wdata:       bus.req_wdata_i};
                        if (req_err || req_noop) begin
                            state_reg      <= ST_RESP;
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= req_err;
                            resp_rdata_reg <= '0;
                        end else if (bus.req_load_i || bus.req_size_i != SZ_WORD) begin
                            state_reg    <= ST_RD;
                            mem_rd_reg   <= 1'b1;
                            mem_addr_reg <= {bus.req_addr_i[31:2], 2'b00};
                            cnt_reg      <= CNT_LOAD;
                        end else begin
                            state_reg     <= ST_WR;
                            mem_wr_reg    <= 1'b1;
                            mem_addr_reg  <= {bus.req_addr_i[31:2], 2'b00};
                            mem_wdata_reg <= bus.req_wdata_i;
                        end
                    end
                end
                ST_RD: begin
                    if (cnt_reg == '0) begin
                        mem_rd_reg <= 1'b0;
                        if (req_reg.load) begin
                            state_reg      <= ST_RESP;
                            mem_addr_reg   <= '0;
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= 1'b0;
                            resp_rdata_reg <= load_data;
                        end else begin
                            // Read half of a sub-word store done; write the merged word next.
                            state_reg     <= ST_WR;
                            mem_wr_reg    <= 1'b1;
                            mem_addr_reg  <= {req_reg.addr[31:2], 2'b00};
                            mem_wdata_reg <= merged_word;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_WR: begin
                    state_reg      <= ST_RESP;
                    mem_wr_reg     <= 1'b0;
                    mem_addr_reg   <= '0;
                    mem_wdata_reg  <= '0;
                    resp_valid_reg <= 1'b1;
                    resp_err_reg   <= 1'b0;
                    resp_rdata_reg <= '0;
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    ready_reg      <= 1'b1;
                    resp_valid_reg <= 1'b0;
                    resp_err_reg   <= 1'b0;
                    resp_rdata_reg <= '0;
                end
            endcase
        end
    end

    assign bus.stall_o      = (state_reg == ST_IDLE && bus.req_valid_i)
                           || state_reg == ST_RD || state_reg == ST_WR;
    assign bus.req_ready_o  = ready_reg;
    assign bus.mem_rd_o     = mem_rd_reg;
    assign bus.mem_wr_o     = mem_wr_reg;
    assign bus.mem_addr_o   = mem_addr_reg;
    assign bus.mem_wdata_o  = mem_wdata_reg;
    assign bus.resp_valid_o = resp_valid_reg;
    assign bus.resp_err_o   = resp_err_reg;
    assign bus.resp_rdata_o = resp_rdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios then random traffic, checked
// against a word-array reference memory with arithmetic lane rules.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_unit_if mif ();

    mem_access_unit #(.RD_LATENCY(LAT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (mif.slave)
    );

    // Device memory seen by the DUT, and the reference view kept by the model.
    logic [31:0] dev_mem [32];
    logic [31:0] ref_mem [32];
    logic        load_mem = 1'b0;

    always @(posedge clk) begin
        if (load_mem)
            dev_mem <= ref_mem;
        else if (mif.mem_wr_o)
            dev_mem[mif.mem_addr_o[6:2]] <= mif.mem_wdata_o;
    end
    assign mif.mem_rdata_i = dev_mem[mif.mem_addr_o[6:2]];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_err(input logic ld, input logic st, input logic [1:0] sz, input logic [31:0] a);
        if (ld && st) return 1'b1;
        if (!ld && !st) return 1'b0;
        if (sz == 2'b11) return 1'b1;
        if (sz == 2'b01) return a[0];
        if (sz == 2'b10) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz, input logic uns, input logic [31:0] a);
        logic [31:0] v;
        case (sz)
            2'b00: begin
                v = (w >> (8 * int'(a[1:0]))) & 32'hFF;
                if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            2'b01: begin
                v = (w >> (16 * int'(a[1]))) & 32'hFFFF;
                if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] w, input logic [31:0] wd, input logic [1:0] sz, input logic [31:0] a);
        logic [31:0] mask;
        int          sh;
        case (sz)
            2'b00: begin sh = 8 * int'(a[1:0]); mask = 32'hFF << sh;   return (w & ~mask) | ((wd & 32'hFF) << sh);   end
            2'b01: begin sh = 16 * int'(a[1]);  mask = 32'hFFFF << sh; return (w & ~mask) | ((wd & 32'hFFFF) << sh); end
            default: return wd;
        endcase
    endfunction

    task automatic pulse_mem_load();
        @(negedge clk); load_mem = 1'b1;
        @(negedge clk); load_mem = 1'b0;
    endtask

    // One complete transaction; keep leaves req_valid_i high for a back-to-back follow-up.
    task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input bit keep);
        logic        err;
        int          lat, exp_rd, exp_wr, k, rd_n, wr_n;
        bit          got;
        logic [31:0] old_w, exp_wdata, exp_rdata, waddr;
        old_w     = ref_mem[a[6:2]];
        waddr     = {a[31:2], 2'b00};
        err       = ref_err(ld, st, sz, a);
        exp_rd    = 0;
        exp_wr    = 0;
        exp_rdata = 32'h0;
        exp_wdata = ref_merge(old_w, wd, sz, a);
        if (err || (!ld && !st)) lat = 1;
        else if (ld) begin lat = LAT + 1; exp_rd = LAT; exp_rdata = ref_load(old_w, sz, uns, a); end
        else if (sz == 2'b10) begin lat = 2; exp_wr = 1; end
        else begin lat = LAT + 2; exp_rd = LAT; exp_wr = 1; end

        @(negedge clk);
        mif.req_load_i     = ld;
        mif.req_store_i    = st;
        mif.req_size_i     = sz;
        mif.req_unsigned_i = uns;
        mif.req_addr_i     = a;
        mif.req_wdata_i    = wd;
        mif.req_valid_i    = 1'b1;
        #1;
        chk("accept_ready", 32'(mif.req_ready_o), 32'd1);
        chk("accept_stall", 32'(mif.stall_o), 32'd1);
        @(posedge clk); #1;
        if (!keep) mif.req_valid_i = 1'b0;

        k = 0; got = 1'b0; rd_n = 0; wr_n = 0;
        while (!got && k < 4 * LAT + 10) begin
            @(negedge clk);
            k++;
            chk("strobe_overlap", 32'(mif.mem_rd_o & mif.mem_wr_o), 32'd0);
            if (mif.mem_rd_o) begin
                rd_n++;
                chk("rd_addr", mif.mem_addr_o, waddr);
                chk("rd_before_wr", wr_n, 0);
            end else if (mif.mem_wr_o) begin
                wr_n++;
                chk("wr_addr", mif.mem_addr_o, waddr);
                chk("wr_data", mif.mem_wdata_o, exp_wdata);
            end else begin
                chk("bus_idle_addr", mif.mem_addr_o, 32'h0);
                chk("bus_idle_wdata", mif.mem_wdata_o, 32'h0);
            end
            if (mif.resp_valid_o) begin
                got = 1'b1;
                chk("resp_latency", k, lat);
                chk("resp_err", 32'(mif.resp_err_o), 32'(err));
                chk("resp_rdata", mif.resp_rdata_o, exp_rdata);
                chk("resp_stall", 32'(mif.stall_o), 32'd0);
                chk("resp_ready", 32'(mif.req_ready_o), 32'd0);
            end else begin
                chk("busy_stall", 32'(mif.stall_o), 32'd1);
                chk("busy_ready", 32'(mif.req_ready_o), 32'd0);
            end
        end
        chk("resp_seen", 32'(got), 32'd1);
        chk("rd_cycles", rd_n, exp_rd);
        chk("wr_cycles", wr_n, exp_wr);
        if (st && !ld && !err) ref_mem[a[6:2]] = exp_wdata;
        $display("txn ld=%0d st=%0d size=%0d uns=%0d addr=0x%08h wdata=0x%08h -> err=%0d rdata=0x%08h resp_cycle=%0d",
                 ld, st, sz, uns, a, wd, mif.resp_err_o, mif.resp_rdata_o, k);
    endtask

    // Byte load or byte store interrupted by reset during its second RD cycle.
    task automatic reset_during_rd(input logic st, input logic [31:0] a);
        @(negedge clk);
        mif.req_load_i     = ~st;
        mif.req_store_i    = st;
        mif.req_size_i     = 2'b00;
        mif.req_unsigned_i = 1'b0;
        mif.req_addr_i     = a;
        mif.req_wdata_i    = 32'h0000_0055;
        mif.req_valid_i    = 1'b1;
        @(posedge clk); #1;
        mif.req_valid_i = 1'b0;
        @(negedge clk);
        chk("rst_rd_cycle1", 32'(mif.mem_rd_o), 32'd1);
        @(posedge clk); #1;
        chk("rst_rd_cycle2", 32'(mif.mem_rd_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_rd_drop", 32'(mif.mem_rd_o), 32'd0);
        chk("rst_wr_low", 32'(mif.mem_wr_o), 32'd0);
        chk("rst_addr_clr", mif.mem_addr_o, 32'h0);
        chk("rst_no_resp", 32'(mif.resp_valid_o), 32'd0);
        chk("rst_ready", 32'(mif.req_ready_o), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_resp", 32'(mif.resp_valid_o), 32'd0);
            chk("post_rst_no_strobe", 32'(mif.mem_rd_o | mif.mem_wr_o), 32'd0);
            chk("post_rst_ready", 32'(mif.req_ready_o), 32'd1);
        end
        $display("txn reset during RD st=%0d addr=0x%08h abandoned", st, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ld, st, uns, keep;
        logic [1:0]  sz;
        logic [31:0] a, wd;
        int          pick;

        mif.req_valid_i    = 1'b0;
        mif.req_load_i     = 1'b0;
        mif.req_store_i    = 1'b0;
        mif.req_size_i     = 2'b00;
        mif.req_unsigned_i = 1'b0;
        mif.req_addr_i     = 32'h0;
        mif.req_wdata_i    = 32'h0;
        for (int i = 0; i < 32; i++) ref_mem[i] = $urandom;
        load_mem = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        load_mem = 1'b0;
        chk("reset_ready", 32'(mif.req_ready_o), 32'd1);
        chk("reset_stall", 32'(mif.stall_o), 32'd0);
        chk("reset_rd", 32'(mif.mem_rd_o), 32'd0);
        chk("reset_wr", 32'(mif.mem_wr_o), 32'd0);
        chk("reset_resp_valid", 32'(mif.resp_valid_o), 32'd0);
        chk("reset_resp_err", 32'(mif.resp_err_o), 32'd0);
        chk("reset_rdata", mif.resp_rdata_o, 32'h0);
        chk("reset_addr", mif.mem_addr_o, 32'h0);
        chk("reset_wdata", mif.mem_wdata_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Word store then load back.
        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF, 1'b0);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1'b0);
        chk("word_roundtrip", ref_mem[2], 32'hDEAD_BEEF);

        // Byte read-modify-write into a known word.
        ref_mem[1] = 32'h1122_3344;
        pulse_mem_load();
        issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h5, 32'h0000_00AA, 1'b0);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0);

        // Half load sign/zero extension.
        ref_mem[0] = 32'h0000_8000;
        pulse_mem_load();
        issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h0, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h0, 32'h0, 1'b0);

        // Error and no-op requests.
        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h6, 32'h1234_5678, 1'b0);
        issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b0);
        issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);

        // Reset during the read phase: no response, no write, data untouched.
        reset_during_rd(1'b0, 32'h21);
        reset_during_rd(1'b1, 32'h22);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);

        // Back-to-back with valid held across the first response.
        issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h7, 32'h0, 1'b1);
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h2, 32'h0000_BEEF, 1'b0);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            pick = int'($urandom_range(0, 9));
            ld   = (pick == 0) || (pick >= 2 && pick <= 5);
            st   = (pick == 0) || (pick >= 6);
            sz   = 2'($urandom_range(0, 3));
            if (sz == 2'b11 && $urandom_range(0, 1) == 1) sz = 2'b10;
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            uns  = 1'($urandom_range(0, 1));
            wd   = $urandom;
            keep = (n != 59) && ($urandom_range(0, 2) == 0);
            issue(ld, st, sz, uns, a, wd, keep);
        end

        // Read every word back to confirm memory contents match the model.
        for (int w = 0; w < 32; w++)
            issue(1'b1, 1'b0, 2'b10, 1'b0, 32'(w * 4), 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
